ram_dp_be: RTL
==============

RAM_DP_BE -- requirements
Module: ram_dp_be

Interface
REQ-001 Parameter AW, default 3: address width; the memory holds 2**AW words.
REQ-002 Parameter DW, default 8: data width in bits.
REQ-003 Parameter LW, default 4: byte-lane width in bits; DW SHALL be an integer multiple of LW; NL = DW/LW lanes.
REQ-004 Parameter RD_LAT, default 1: read latency in cycles; legal values are 1 and 2.
REQ-005 Parameter COLL_MODE, default 0: same-address read/write collision policy; 0 = read-old, 1 = write-through.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 addrr  input  AW  read address.
REQ-009 addrw  input  AW  write address.
REQ-010 rw  input  2  operation code: 00 idle, 01 write, 10 read, 11 read and write.
REQ-011 data_in  input  DW  write data.
REQ-012 wbe  input  NL  write lane enables; bit k enables data_in[k*LW +: LW].
REQ-013 clr_req  input  1  single-cycle request to re-zero the whole array.
REQ-014 data_out_c  output  DW  read data.
REQ-015 rd_valid  output  1  high for one cycle when data_out_c carries a read result.
REQ-016 busy  output  1  high while the clear sweep runs.

Function
REQ-017 The controller SHALL have two states, INIT (clear sweep) and RUN; it enters INIT from reset and on an accepted clr_req.
REQ-018 In INIT, a sweep counter SHALL write all-zero to address 0, 1, ..., 2**AW-1, one address per cycle, then move to RUN on the following edge; busy SHALL be high for exactly 2**AW cycles.
REQ-019 In INIT, rw, wbe, addrr, addrw and data_in SHALL be ignored, and no read SHALL be accepted.
REQ-020 In RUN, with rw=01 or rw=11, each lane k with wbe[k]=1 SHALL be written at addrw; lanes with wbe[k]=0 SHALL keep their contents.
REQ-021 In RUN, rw=01 with wbe all-zero SHALL leave the memory unchanged.
REQ-022 In RUN, with rw=10 or rw=11, the read of addrr SHALL be accepted, and data_out_c/rd_valid SHALL present it exactly RD_LAT cycles after the accepting edge.
REQ-023 With RD_LAT=2, accepted reads SHALL pipeline back-to-back at one per cycle with no bubbles.
REQ-024 On a cycle where rd_valid is 0, data_out_c SHALL be all-zero.
REQ-025 If rw=11 and addrr==addrw with COLL_MODE=0, the read SHALL return the pre-write word.
REQ-026 If rw=11 and addrr==addrw with COLL_MODE=1, the read SHALL return a merged word: data_in lanes where wbe=1, pre-write lanes elsewhere.
REQ-027 If addrr!=addrw, the read and write SHALL be independent.
REQ-028 A write at address A followed by a read of A on the next cycle SHALL return the new data, for either COLL_MODE.
REQ-029 clr_req in RUN SHALL be accepted at that edge: the rw operation of that cycle is discarded, and INIT starts at address 0 on the next cycle.
REQ-030 Reads accepted before clr_req SHALL still complete with their original data and timing.
REQ-031 clr_req during INIT SHALL restart the sweep at address 0; busy stays high for a further 2**AW cycles.
REQ-032 The sweep counter SHALL be AW+1 bits wide, so the terminal address 2**AW-1 is written before the state change without wrap-around ambiguity.

Reset
REQ-033 reset=0 SHALL immediately, without waiting for clk, force data_out_c=0, rd_valid=0, busy=1, the state to INIT, the sweep counter to 0, and the read pipeline to empty.
REQ-034 Memory contents SHALL NOT be reset asynchronously; they are zeroed by the INIT sweep after reset is released.
REQ-035 Assertion of reset during INIT or RUN, including with reads in flight, SHALL discard all pending reads; no rd_valid SHALL follow.
REQ-036 The sweep SHALL begin on the first clk edge with reset=1.

Verification (AW=3, DW=8, LW=4)
REQ-037 Release reset, hold rw=10 with addrr=5 -> busy high for 8 cycles with no rd_valid; after RUN, data_out_c=0x00 with rd_valid at RD_LAT.
REQ-038 Write 0xA5 with wbe=11 at address 2, then write 0x3C with wbe=01 at address 2, then read 2 -> data_out_c=0xAC.
REQ-039 Memory [4]=0x11, rw=11, addrr=addrw=4, data_in=0xFF, wbe=10 -> COLL_MODE=0 returns 0x11; COLL_MODE=1 returns 0xF1; a later read returns 0xF1.
REQ-040 RD_LAT=2, reads of 0..7 on consecutive cycles, then clr_req in the cycle after the last read -> 8 rd_valid pulses with the correct data, busy for 8 cycles, then a read of any address returns 0x00.
REQ-041 Assert reset with two reads in flight (RD_LAT=2) -> data_out_c=0 and rd_valid=0 immediately, no later rd_valid, busy=1.
REQ-042 clr_req during the 5th sweep cycle -> busy stays high for 4+8=12 cycles in total.

Source files
------------

// File: rtl/ram_dp_be.sv
// ram_dp_be: dual-port RAM with byte-lane write enables, a power-up/on-demand clear sweep,
// a configurable read latency (1 or 2) and a selectable same-address collision policy.
module ram_dp_be #(
   parameter int AW        = 3,
   parameter int DW        = 8,
   parameter int LW        = 4,
   parameter int RD_LAT    = 1,
   parameter int COLL_MODE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    addrr,
   input  logic [AW-1:0]    addrw,
   input  logic [1:0]       rw,
   input  logic [DW-1:0]    data_in,
   input  logic [DW/LW-1:0] wbe,
   input  logic             clr_req,
   output logic [DW-1:0]    data_out_c,
   output logic             rd_valid,
   output logic             busy
);
   localparam int NL = DW / LW;

   typedef enum logic {INIT, RUN} state_t;

   state_t          state_q, state_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic [AW-1:0]   sweep_a, wa;
   logic [DW-1:0]   wd, rword;
   logic [NL-1:0]   we;
   logic            rd;
   logic            v1_q;
   logic [DW-1:0]   d1_q;
   logic [DW-1:0]   mem_q [2**AW];

   assign busy = (state_q == INIT);

   // A clear request during the sweep makes the current cycle the first of a fresh sweep.
   always_comb begin
      sweep_a = clr_req ? '0 : cnt_q[AW-1:0];
      cnt_d   = cnt_q;
      state_d = state_q;
      wa      = addrw;
      wd      = data_in;
      we      = '0;
      rd      = 1'b0;
      if (state_q == INIT) begin
         cnt_d   = (clr_req ? '0 : cnt_q) + (AW+1)'(1);
         state_d = cnt_d[AW] ? RUN : INIT;
         wa      = sweep_a;
         wd      = '0;
         we      = '1;
      end else if (clr_req) begin
         cnt_d   = '0;
         state_d = INIT;
      end else begin
         we = rw[0] ? wbe : '0;
         rd = rw[1];
      end
   end

   always_comb begin
      rword = mem_q[addrr];
      for (int k = 0; k < NL; k++)
         if (COLL_MODE == 1 && we[k] && addrr == wa)
            rword[k*LW +: LW] = wd[k*LW +: LW];
   end

   always_ff @(posedge clk)
      for (int k = 0; k < NL; k++)
         if (we[k]) mem_q[wa][k*LW +: LW] <= wd[k*LW +: LW];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= INIT;
         cnt_q   <= '0;
         v1_q    <= 1'b0;
         d1_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         v1_q    <= rd;
         d1_q    <= rd ? rword : '0;
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic          v2_q;
         logic [DW-1:0] d2_q;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               v2_q <= 1'b0;
               d2_q <= '0;
            end else begin
               v2_q <= v1_q;
               d2_q <= d1_q;
            end
         end
         assign rd_valid   = v2_q;
         assign data_out_c = d2_q;
      end else begin : g_lat1
         assign rd_valid   = v1_q;
         assign data_out_c = d1_q;
      end
   endgenerate
endmodule
